whackamole_game_ctrl: RTL and testbench
=======================================

Name: whackamole_game_ctrl

Overview:
- Game-logic producer for the whack-a-mole VGA display. It drives the mole position, the correct/wrong feedback flags and the two BCD score digits.
- Consumes debounced one-cycle hit pulses and a start pulse from the button/switch front end.
- Sequences rounds with internal cycle timers. Picks mole positions from an LFSR.
- Sits between the input conditioning logic and vga_display, in the master_clk domain.

Parameters:
- NUM_HOLES, 8, number of mole holes (2..8); mole_position ranges 0..NUM_HOLES-1.
- MOLE_CYCLES, 50000000, clk cycles a mole stays up before counting as a miss.
- FEEDBACK_CYCLES, 25000000, clk cycles guess_correct/guess_wrong are held.
- ROUNDS, 20, moles per game (1..255).

Ports:
- clk  input  1  system clock (master_clk)
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a game from IDLE or DONE
- hit_pulse  input  1  one-cycle pulse; player struck hole hit_position
- hit_position  input  3  hole index accompanying hit_pulse
- mole_visible  output  1  high while a mole is up (SHOW state)
- mole_position  output  3  current mole hole index
- guess_correct  output  1  high throughout FEEDBACK after a correct hit
- guess_wrong  output  1  high throughout FEEDBACK after a wrong hit or timeout
- digit_1  output  4  score tens digit, BCD 0..9
- digit_2  output  4  score ones digit, BCD 0..9
- game_over  output  1  high in DONE

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, all outputs 0, timer=0, round count=0, lfsr=8'hA5.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every clk cycle, including in IDLE.
  - Never all-zero.
- Next-position rule:
  - cand = lfsr[2:0]; if cand >= NUM_HOLES, cand -= NUM_HOLES.
  - If cand == current mole_position, cand = (cand+1) mod NUM_HOLES.
  - Consecutive moles therefore never share a hole.
- IDLE: mole_visible=0. start -> clear score to 00, round=0, load mole_position with next-position, timer=0 -> SHOW.
- SHOW: mole_visible=1; timer increments each cycle. Priority, highest first:
  - hit_pulse && hit_position==mole_position: score+1 (BCD, saturate at 99), guess_correct=1 -> FEEDBACK.
  - hit_pulse with any other position (including >= NUM_HOLES): guess_wrong=1, score unchanged -> FEEDBACK.
  - timer == MOLE_CYCLES-1 with no hit: guess_wrong=1 -> FEEDBACK.
  - A hit on the same cycle as timeout is scored as a hit.
- Transition to FEEDBACK: mole_visible drops the cycle after the transition; timer cleared; round increments.
- FEEDBACK:
  - hit_pulse and start are ignored.
  - After FEEDBACK_CYCLES cycles: flags clear.
  - If round == ROUNDS -> DONE. Otherwise load next-position, timer=0 -> SHOW.
- DONE: game_over=1, mole_visible=0, score held. start -> same as start in IDLE, game_over=0.
- start in SHOW or FEEDBACK is ignored.
- guess_correct and guess_wrong are never high together.
- BCD increment: digit_2==9 -> digit_2=0, digit_1+1. Score 99 stays 99.
- Outputs update one cycle after the causing input (registered latency 1).
- rst mid-game returns to the reset values on the next edge, regardless of state.

Test Plan (MOLE_CYCLES=10, FEEDBACK_CYCLES=4, ROUNDS=3, NUM_HOLES=8):
- Reset then idle 20 cycles -> all outputs 0, game_over=0. Pulse start -> next cycle mole_visible=1, digits 0/0.
- In SHOW, pulse hit_pulse with hit_position=mole_position -> next cycle guess_correct=1 for exactly 4 cycles, digit_2=1, then a new mole appears with a different position.
- In SHOW, hit wrong hole -> guess_wrong=1 for 4 cycles, score unchanged. Separately, no hit -> guess_wrong asserts 10 cycles after mole_visible rose.
- Hit pulse on the timeout cycle -> scored as correct. start/hit during FEEDBACK -> no effect.
- Three correct rounds -> game_over=1, score 0/3, mole_visible=0. start -> score 0/0, game_over=0.
- Preload via 99 correct hits (ROUNDS=120) -> digits 9/9, extra hit stays 9/9. Assert rst mid-SHOW -> all outputs 0 next cycle.

Source files
------------

// File: rtl/whackamole_game_ctrl.sv
// Whack-a-mole round sequencer: mole placement, hit scoring, feedback flags.
// Ports: clk/rst (sync, active-high), start/hit_pulse/hit_position in;
//   mole_visible, mole_position, guess_correct, guess_wrong,
//   digit_1 (tens), digit_2 (ones), game_over out. All outputs registered.
module whackamole_game_ctrl #(
   parameter int NUM_HOLES       = 8,
   parameter int MOLE_CYCLES     = 50000000,
   parameter int FEEDBACK_CYCLES = 25000000,
   parameter int ROUNDS          = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       hit_pulse,
   input  logic [2:0] hit_position,
   output logic       mole_visible,
   output logic [2:0] mole_position,
   output logic       guess_correct,
   output logic       guess_wrong,
   output logic [3:0] digit_1,
   output logic [3:0] digit_2,
   output logic       game_over
);

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      FEEDBACK,
      DONE
   } state_t;

   localparam logic [31:0] MOLE_LAST = 32'(MOLE_CYCLES - 1);
   localparam logic [31:0] FB_LAST   = 32'(FEEDBACK_CYCLES - 1);
   localparam logic [7:0]  LAST_RND  = 8'(ROUNDS);
   localparam logic [2:0]  TOP_HOLE  = 3'(NUM_HOLES - 1);

   state_t      state;
   logic [31:0] timer;
   logic [7:0]  round;
   logic [7:0]  lfsr;

   logic        lfsr_fb;
   logic [2:0]  cand;
   logic [2:0]  next_pos;
   logic        hit_ok;
   logic        show_end;

   always_comb begin
      lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
      // Modulo equals one conditional subtract for NUM_HOLES >= 4 and
      // keeps small hole counts in range as well.
      cand     = 3'(32'(lfsr[2:0]) % 32'(NUM_HOLES));
      next_pos = cand;
      if (cand == mole_position) begin
         next_pos = (cand == TOP_HOLE) ? 3'd0 : cand + 3'd1;
      end
      hit_ok   = hit_pulse && (hit_position == mole_position);
      show_end = hit_pulse || (timer == MOLE_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         timer         <= '0;
         round         <= '0;
         lfsr          <= 8'hA5;
         mole_visible  <= 1'b0;
         mole_position <= '0;
         guess_correct <= 1'b0;
         guess_wrong   <= 1'b0;
         digit_1       <= '0;
         digit_2       <= '0;
         game_over     <= 1'b0;
      end else begin
         // Free-running so mole placement depends on player timing.
         lfsr <= {lfsr[6:0], lfsr_fb};
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  digit_1       <= '0;
                  digit_2       <= '0;
                  round         <= '0;
                  timer         <= '0;
                  mole_position <= next_pos;
                  mole_visible  <= 1'b1;
                  game_over     <= 1'b0;
                  state         <= SHOW;
               end
            end
            SHOW: begin
               if (show_end) begin
                  // A hit wins over a coincident timeout.
                  if (hit_ok) begin
                     guess_correct <= 1'b1;
                     if (digit_2 != 4'd9) begin
                        digit_2 <= digit_2 + 4'd1;
                     end else if (digit_1 != 4'd9) begin
                        digit_2 <= 4'd0;
                        digit_1 <= digit_1 + 4'd1;
                     end
                  end else begin
                     guess_wrong <= 1'b1;
                  end
                  mole_visible <= 1'b0;
                  timer        <= '0;
                  round        <= round + 8'd1;
                  state        <= FEEDBACK;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            FEEDBACK: begin
               if (timer == FB_LAST) begin
                  guess_correct <= 1'b0;
                  guess_wrong   <= 1'b0;
                  timer         <= '0;
                  if (round == LAST_RND) begin
                     game_over <= 1'b1;
                     state     <= DONE;
                  end else begin
                     mole_position <= next_pos;
                     mole_visible  <= 1'b1;
                     state         <= SHOW;
                  end
               end else begin
                  timer <= timer + 32'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_whackamole_game_ctrl.sv
// Directed bench for whackamole_game_ctrl: two instances (3 and 120 rounds)
// share stimulus; instance b is used for score saturation.
module tb_whackamole_game_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       hit_pulse = 1'b0;
   logic [2:0] hit_position = 3'd0;

   logic       a_vis, a_gc, a_gw, a_go;
   logic [2:0] a_pos;
   logic [3:0] a_d1, a_d2;
   logic       b_vis, b_gc, b_gw, b_go;
   logic [2:0] b_pos;
   logic [3:0] b_d1, b_d2;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_lfsr;
   logic [2:0] exp_pos;
   int         exp_score;

   always #5 clk = ~clk;

   whackamole_game_ctrl #(
      .NUM_HOLES(8), .MOLE_CYCLES(10), .FEEDBACK_CYCLES(4), .ROUNDS(3)
   ) u_a (
      .clk(clk), .rst(rst), .start(start), .hit_pulse(hit_pulse),
      .hit_position(hit_position), .mole_visible(a_vis),
      .mole_position(a_pos), .guess_correct(a_gc), .guess_wrong(a_gw),
      .digit_1(a_d1), .digit_2(a_d2), .game_over(a_go)
   );

   whackamole_game_ctrl #(
      .NUM_HOLES(8), .MOLE_CYCLES(10), .FEEDBACK_CYCLES(4), .ROUNDS(120)
   ) u_b (
      .clk(clk), .rst(rst), .start(start), .hit_pulse(hit_pulse),
      .hit_position(hit_position), .mole_visible(b_vis),
      .mole_position(b_pos), .guess_correct(b_gc), .guess_wrong(b_gw),
      .digit_1(b_d1), .digit_2(b_d2), .game_over(b_go)
   );

   // Reference LFSR: x^8+x^6+x^5+x^4, seed A5, steps every cycle.
   always @(posedge clk) begin
      if (rst) m_lfsr <= 8'hA5;
      else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic logic [2:0] npos(input logic [7:0] l, input logic [2:0] cur);
      int c;
      c = int'(l[2:0]);
      if (c >= 8) c = c - 8;
      if (c == int'(cur)) c = (c + 1) % 8;
      return 3'(c);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      exp_pos = 3'd0;
      checks++;
      if ({a_vis, a_gc, a_gw, a_go} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", {a_vis, a_gc, a_gw, a_go});
      end
      checks++;
      if ({a_pos, a_d1, a_d2} !== 11'd0) begin
         errors++;
         $display("FAIL reset_pos_digits got %h want 0", {a_pos, a_d1, a_d2});
      end
   endtask

   task automatic do_start(input string tag);
      exp_pos = npos(m_lfsr, exp_pos);
      exp_score = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({a_vis, a_go, a_gc, a_gw} !== 4'b1000) begin
         errors++;
         $display("FAIL %s_flags got %b want 1000", tag, {a_vis, a_go, a_gc, a_gw});
      end
      checks++;
      if (a_pos !== exp_pos) begin
         errors++;
         $display("FAIL %s_pos got %0d want %0d", tag, a_pos, exp_pos);
      end
      checks++;
      if ({a_d1, a_d2} !== 8'h00) begin
         errors++;
         $display("FAIL %s_score got %h want 00", tag, {a_d1, a_d2});
      end
   endtask

   // Called at the negedge where the SHOW-ending input is applied.
   task automatic watch_fb(input string tag, input bit want_c,
                           input bit last, input bit poke);
      logic [2:0] prev;
      prev = exp_pos;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         hit_pulse = 1'b0;
         start = 1'b0;
         checks++;
         if ({a_gc, a_gw, a_vis} !== {want_c, !want_c, 1'b0}) begin
            errors++;
            $display("FAIL %s_fb%0d got %b want %b", tag, i,
                     {a_gc, a_gw, a_vis}, {want_c, !want_c, 1'b0});
         end
         checks++;
         if ({a_d1, a_d2} !== {4'(exp_score / 10), 4'(exp_score % 10)}) begin
            errors++;
            $display("FAIL %s_score%0d got %h want %0d", tag, i,
                     {a_d1, a_d2}, exp_score);
         end
         if (poke && i == 2) begin
            start = 1'b1;
            hit_pulse = 1'b1;
            hit_position = prev;
         end
         if (i == 4 && !last) exp_pos = npos(m_lfsr, prev);
      end
      @(negedge clk);
      checks++;
      if ({a_gc, a_gw} !== 2'b00) begin
         errors++;
         $display("FAIL %s_flags_clear got %b want 00", tag, {a_gc, a_gw});
      end
      checks++;
      if ({a_vis, a_go} !== {!last, last}) begin
         errors++;
         $display("FAIL %s_next got %b want %b", tag, {a_vis, a_go}, {!last, last});
      end
      if (!last) begin
         checks++;
         if (a_pos !== exp_pos || a_pos === prev) begin
            errors++;
            $display("FAIL %s_newpos got %0d want %0d (prev %0d)", tag,
                     a_pos, exp_pos, prev);
         end
      end
   endtask

   task automatic test_correct(input bit last);
      hit_pulse = 1'b1;
      hit_position = exp_pos;
      exp_score++;
      watch_fb("correct", 1'b1, last, 1'b0);
   endtask

   task automatic test_wrong(input bit last);
      hit_pulse = 1'b1;
      hit_position = exp_pos + 3'd1;
      watch_fb("wrong", 1'b0, last, 1'b0);
   endtask

   task automatic wait_nine(input string tag);
      int bad;
      bad = 0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (a_vis !== 1'b1 || a_gw !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s_early got %0d bad cycles want 0", tag, bad);
      end
   endtask

   task automatic test_timeout(input bit last);
      wait_nine("timeout");
      watch_fb("timeout", 1'b0, last, 1'b0);
   endtask

   task automatic test_hit_on_timeout();
      wait_nine("hit_to");
      hit_pulse = 1'b1;
      hit_position = exp_pos;
      exp_score++;
      watch_fb("hit_to", 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_saturate();
      int got_vis;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_pos = 3'd0;
      do_start("sat_start");
      for (int n = 1; n <= 100; n++) begin
         hit_pulse = 1'b1;
         hit_position = b_pos;
         @(negedge clk);
         hit_pulse = 1'b0;
         if (n == 10 || n == 99 || n == 100) begin
            checks++;
            if ({b_d1, b_d2} !== ((n == 10) ? 8'h10 : 8'h99) || b_gc !== 1'b1) begin
               errors++;
               $display("FAIL sat_%0d got %h gc %b want %0d gc 1", n,
                        {b_d1, b_d2}, b_gc, (n == 10) ? 10 : 99);
            end
         end
         got_vis = 0;
         for (int k = 0; k < 10 && got_vis == 0; k++) begin
            @(negedge clk);
            if (b_vis === 1'b1) got_vis = 1;
         end
         if (got_vis == 0) begin
            checks++;
            errors++;
            $display("FAIL sat_wait got timeout want mole_visible");
            break;
         end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({b_vis, b_pos, b_gc, b_gw, b_d1, b_d2, b_go} !== 15'd0) begin
         errors++;
         $display("FAIL rst_mid_show got %h want 0",
                  {b_vis, b_pos, b_gc, b_gw, b_d1, b_d2, b_go});
      end
      checks++;
      if ({a_vis, a_pos, a_gc, a_gw, a_d1, a_d2, a_go} !== 15'd0) begin
         errors++;
         $display("FAIL rst_a got %h want 0",
                  {a_vis, a_pos, a_gc, a_gw, a_d1, a_d2, a_go});
      end
   endtask

   initial begin
      test_reset();
      do_start("start1");
      test_correct(1'b0);
      test_wrong(1'b0);
      test_timeout(1'b1);
      checks++;
      if ({a_d1, a_d2} !== 8'h01) begin
         errors++;
         $display("FAIL done1_score got %h want 01", {a_d1, a_d2});
      end
      do_start("restart");
      test_hit_on_timeout();
      test_correct(1'b0);
      test_correct(1'b1);
      checks++;
      if ({a_d1, a_d2, a_vis} !== {8'h03, 1'b0}) begin
         errors++;
         $display("FAIL done2 got %h vis %b want 03 vis 0", {a_d1, a_d2}, a_vis);
      end
      do_start("restart2");
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
